regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter that shares the register file's single write port among NUM_REQ writeback requesters, such as the ALU result path, the memory-load path and the immediate-load path. Each requester presents a register ID and data with a valid/ready handshake. The arbiter grants one requester per cycle and drives a registered write command (enable, register ID, data) straight onto the register file's write port. It sits between the execute/memory stages and the register file and is the only block allowed to drive that write port.

## Interface
- WORD_LENGTH, 8, data word width; matches the register file.
- ID_LENGTH, 3, register ID width; matches the register file.
- NUM_REQ, 4, number of requesters; legal range 2..8.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i high means requester i has a write pending.
- req_id  in  NUM_REQ*ID_LENGTH  packed destination register IDs; requester i occupies bits [i*ID_LENGTH +: ID_LENGTH].
- req_data  in  NUM_REQ*WORD_LENGTH  packed write data; requester i occupies bits [i*WORD_LENGTH +: WORD_LENGTH].
- req_ready  out  NUM_REQ  one-hot or zero; bit i high means requester i is granted this cycle.
- wr_hold  in  1  register-file owner stalls the port; no grants while high.
- wr_en  out  1  write enable to the register file; registered.
- wr_reg  out  ID_LENGTH  destination register ID to the register file; registered.
- wr_data  out  WORD_LENGTH  write data to the register file; registered.
- last_grant  out  NUM_REQ  one-hot index of the most recently accepted requester; registered; debug.

## Operation
- **Round-robin pointer.**
  - rr_ptr has width ceil(log2(NUM_REQ)) and resets to 0.
  - Each cycle, search order is rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …, rr_ptr-1.
  - The first requester i with req_valid[i]=1 is the candidate.
- **req_ready.**
  - Combinational: req_ready[i] = candidate==i & !wr_hold & !rst.
  - At most one bit is high. All bits are zero when no requester is valid.
- **Transfer.**
  - A transfer occurs on a rising clk edge where req_valid[i] & req_ready[i] are both high.
  - On that edge:
    - wr_en <= 1
    - wr_reg <= req_id slice i
    - wr_data <= req_data slice i
    - last_grant <= one-hot(i)
    - rr_ptr <= (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- **No transfer.**
  - On an edge with no transfer, wr_en <= 0.
  - wr_reg, wr_data, last_grant and rr_ptr hold their values.
- **Requester rules.**
  - A requester holds valid, id and data stable until it sees ready high at a rising edge.
  - A requester may drop valid only after a transfer.
  - The arbiter does not buffer requests; un-granted requesters simply wait.
- **Fairness.** A continuously valid requester is granted within NUM_REQ cycles in which wr_hold is low.
- **Same destination register.**
  - Two requesters targeting the same register are serialized in grant order; the later grant wins in the register file.
  - The arbiter does not compare IDs.
- **wr_hold.**
  - While wr_hold is high: req_ready is all zero, and wr_en drops to 0 on the next edge.
  - A command already on the port when wr_hold rises is still written, because the register file latches it on that same edge.
  - The rr_ptr position is preserved across the hold.
- **Reset.**
  - Applies immediately, without waiting for clk.
  - wr_en=0, wr_reg=0, wr_data=0, last_grant=0, rr_ptr=0, req_ready=0.
  - A request in flight when reset asserts is dropped. The requester re-presents it after reset.

## Timing
- **Grant latency.** req_ready rises in the same cycle as req_valid, provided the requester is the candidate and wr_hold is low.
- **Write latency.**
  - wr_en, wr_reg and wr_data are valid during the cycle after the transfer edge.
  - The register file latches the value at the following edge.
  - The write is therefore visible on register-file reads two edges after the transfer.
- **Throughput.** One write per cycle when any requester is valid and wr_hold is low. There are no bubbles between consecutive grants.
- **Single requester.** The pointer advances past the granted requester, but if it remains the only valid requester it is still the candidate, so it is granted every cycle.
- **Glitch freedom.** req_ready depends only on req_valid, rr_ptr, wr_hold and rst; it never depends on req_id or req_data.

## Test plan
- **Reset values.** Assert rst mid-cycle with requests valid -> immediately wr_en=0, req_ready=0000, last_grant=0000. After release, the first grant goes to requester 0.
- **Single requester.** Requester 2 presents id=5, data=0xA7 for 1 cycle -> req_ready=0100 that cycle. Next cycle wr_en=1, wr_reg=5, wr_data=0xA7. The cycle after, wr_en=0 and register 5 reads 0xA7.
- **All requesters contend.** All 4 requesters are valid continuously from reset -> grant order 0,1,2,3,0,1. wr_en stays high every cycle after the first.
- **Pointer wrap.**
  - Requester 3 is granted, so rr_ptr=0.
  - Then requesters 1 and 3 are both valid -> 1 is granted first, then 3.
- **Hold.** All requesters are valid and wr_hold is high for 3 cycles after a grant to 1 -> req_ready=0000 and wr_en=0 for those cycles. On release, requester 2 is granted.
- **Same destination.** Requester 0 writes id=3 data=0x11 and requester 1 writes id=3 data=0x22, both valid together -> two consecutive writes to register 3. Register 3 finally reads 0x22.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter driving the register file's single write port
module regfile_write_arbiter #(
    parameter int WORD_LENGTH = 8,
    parameter int ID_LENGTH   = 3,
    parameter int NUM_REQ     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*ID_LENGTH-1:0]   req_id_i,
    input  logic [NUM_REQ*WORD_LENGTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic                           wr_hold_i,
    output logic                           wr_en_o,
    output logic [ID_LENGTH-1:0]           wr_reg_o,
    output logic [WORD_LENGTH-1:0]         wr_data_o,
    output logic [NUM_REQ-1:0]             last_grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]       cand;
    logic [PTR_W:0]         idx;
    logic                   found;
    logic                   grant;
    logic [NUM_REQ-1:0]     cand_onehot;

    logic                   wr_en_q, wr_en_d;
    logic [ID_LENGTH-1:0]   wr_reg_q, wr_reg_d;
    logic [WORD_LENGTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_REQ-1:0]     last_grant_q, last_grant_d;

    // Circular search starting at rr_ptr; the extra idx bit absorbs the wrap before the modulo fold.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(NUM_REQ)) begin
                idx = idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!found && req_valid_i[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                cand  = idx[PTR_W-1:0];
            end
        end
    end

    assign grant       = found & ~wr_hold_i & ~rst;
    assign cand_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << cand;
    assign req_ready_o = grant ? cand_onehot : '0;

    always_comb begin
        wr_en_d      = grant;
        wr_reg_d     = wr_reg_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant) begin
            wr_reg_d     = req_id_i[cand*ID_LENGTH +: ID_LENGTH];
            wr_data_d    = req_data_i[cand*WORD_LENGTH +: WORD_LENGTH];
            last_grant_d = cand_onehot;
            rr_ptr_d     = (cand == PTR_W'(NUM_REQ-1)) ? '0 : cand + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            wr_reg_q     <= '0;
            wr_data_q    <= '0;
            last_grant_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_reg_q     <= wr_reg_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_reg_o     = wr_reg_q;
    assign wr_data_o    = wr_data_q;
    assign last_grant_o = last_grant_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int WL = 8;
    localparam int IL = 3;
    localparam int NR = 4;

    logic           clk;
    logic           rst;
    logic [NR-1:0]  req_valid;
    logic [NR*IL-1:0] req_id;
    logic [NR*WL-1:0] req_data;
    logic [NR-1:0]  req_ready;
    logic           wr_hold;
    logic           wr_en;
    logic [IL-1:0]  wr_reg;
    logic [WL-1:0]  wr_data;
    logic [NR-1:0]  last_grant;

    logic [WL-1:0]  rf [0:(1<<IL)-1];

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter #(.WORD_LENGTH(WL), .ID_LENGTH(IL), .NUM_REQ(NR)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_id_i     (req_id),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready),
        .wr_hold_i    (wr_hold),
        .wr_en_o      (wr_en),
        .wr_reg_o     (wr_reg),
        .wr_data_o    (wr_data),
        .last_grant_o (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: latches the write command presented during the previous cycle.
    always @(posedge clk) begin
        if (wr_en) rf[wr_reg] <= wr_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [IL-1:0] id, input logic [WL-1:0] data);
        req_id[i*IL +: IL]   = id;
        req_data[i*WL +: WL] = data;
    endtask

    initial begin
        for (int r = 0; r < (1<<IL); r++) rf[r] = '0;
        rst       = 1'b1;
        req_valid = '0;
        req_id    = '0;
        req_data  = '0;
        wr_hold   = 1'b0;
        #2;
        chk("rst_wr_en",      32'(wr_en),      32'h0);
        chk("rst_req_ready",  32'(req_ready),  32'h0);
        chk("rst_last_grant", 32'(last_grant), 32'h0);
        chk("rst_wr_reg",     32'(wr_reg),     32'h0);
        chk("rst_wr_data",    32'(wr_data),    32'h0);
        tick();
        rst = 1'b0;

        // Single requester 2
        set_req(2, 3'd5, 8'hA7);
        req_valid = 4'b0100;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        chk("single_wr_en",   32'(wr_en),      32'h1);
        chk("single_wr_reg",  32'(wr_reg),     32'h5);
        chk("single_wr_data", 32'(wr_data),    32'hA7);
        chk("single_lg",      32'(last_grant), 32'h4);
        tick();
        chk("single_wr_en_off", 32'(wr_en),    32'h0);
        chk("single_rf5",       32'(rf[5]),    32'hA7);
        chk("single_reg_hold",  32'(wr_reg),   32'h5);

        // Pointer now at 3; grant 3, then reset mid-cycle with all valid
        for (int i = 0; i < NR; i++) set_req(i, 3'(i + 1), 8'(8'h50 + i));
        req_valid = 4'b1111;
        #1;
        chk("ptr3_ready", 32'(req_ready), 32'h8);
        tick();
        chk("ptr3_lg", 32'(last_grant), 32'h8);
        chk("ptr3_en", 32'(wr_en),      32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wr_en",     32'(wr_en),      32'h0);
        chk("arst_ready",     32'(req_ready),  32'h0);
        chk("arst_last_grant",32'(last_grant), 32'h0);
        chk("arst_wr_reg",    32'(wr_reg),     32'h0);
        tick();
        #2;
        rst = 1'b0;
        #1;

        // All contend: order 0,1,2,3,0,1 with no bubbles
        for (int k = 0; k < 6; k++) begin
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            tick();
            chk("rr_en",   32'(wr_en),      32'h1);
            chk("rr_lg",   32'(last_grant), 32'(1 << (k % 4)));
            chk("rr_data", 32'(wr_data),    32'(8'h50 + (k % 4)));
            chk("rr_reg",  32'(wr_reg),     32'((k % 4) + 1));
        end

        // Hold after grant to 1
        wr_hold = 1'b1;
        #1;
        chk("hold_ready0", 32'(req_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_en",    32'(wr_en),      32'h0);
            chk("hold_ready", 32'(req_ready),  32'h0);
            chk("hold_lg",    32'(last_grant), 32'h2);
        end
        wr_hold = 1'b0;
        #1;
        chk("unhold_ready", 32'(req_ready), 32'h4);
        tick();
        chk("unhold_lg",   32'(last_grant), 32'h4);
        chk("unhold_data", 32'(wr_data),    32'h52);

        // Pointer wrap: grant 3, then 1 and 3 valid
        req_valid = 4'b1000;
        #1;
        chk("wrap_ready3", 32'(req_ready), 32'h8);
        tick();
        req_valid = 4'b1010;
        #1;
        chk("wrap_ready1", 32'(req_ready), 32'h2);
        tick();
        chk("wrap_lg1", 32'(last_grant), 32'h2);
        req_valid = 4'b1000;
        #1;
        chk("wrap_ready3b", 32'(req_ready), 32'h8);
        tick();
        chk("wrap_lg3", 32'(last_grant), 32'h8);
        req_valid = 4'b0000;

        // Same destination: 0 then 1 both to register 3
        set_req(0, 3'd3, 8'h11);
        set_req(1, 3'd3, 8'h22);
        req_valid = 4'b0011;
        #1;
        chk("same_ready0", 32'(req_ready), 32'h1);
        tick();
        chk("same_reg0",  32'(wr_reg),  32'h3);
        chk("same_data0", 32'(wr_data), 32'h11);
        req_valid = 4'b0010;
        #1;
        chk("same_ready1", 32'(req_ready), 32'h2);
        tick();
        chk("same_en1",   32'(wr_en),   32'h1);
        chk("same_reg1",  32'(wr_reg),  32'h3);
        chk("same_data1", 32'(wr_data), 32'h22);
        req_valid = 4'b0000;
        tick();
        chk("same_en_off", 32'(wr_en),  32'h0);
        chk("same_rf3",    32'(rf[3]),  32'h22);

        // Lone requester behind the pointer is granted every cycle
        req_valid = 4'b0001;
        #1;
        chk("lone_ready_a", 32'(req_ready), 32'h1);
        tick();
        chk("lone_ready_b", 32'(req_ready), 32'h1);
        tick();
        chk("lone_en", 32'(wr_en), 32'h1);
        req_valid = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
